// File: rtl/midi_voice_alloc.sv
// midi_voice_alloc: polyphonic voice allocator for one MIDI channel (note-on/off, round-robin steal).
// Latency: note-on lands NUM_VOICES+3 cycles after accept; a note-off gate falls the cycle after its voice is scanned.
// Backpressure: msg_busy is high outside IDLE and any msg_valid seen while busy is dropped.
// Optional feature: define MIDI_ALLOC_SUSTAIN_EN to enable the CC64 sustain pedal.
module midi_voice_alloc #(
  parameter int NUM_VOICES = 4,
  parameter int CHANNEL    = 0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    msg_valid,
  input  logic [7:0]              msg_status,
  input  logic [7:0]              msg_data1,
  input  logic [7:0]              msg_data2,
  output logic                    msg_busy,
  output logic [NUM_VOICES-1:0]   voice_gate,
  output logic [7*NUM_VOICES-1:0] voice_note,
  output logic [7*NUM_VOICES-1:0] voice_vel,
  output logic [NUM_VOICES-1:0]   voice_load,
  output logic                    steal
);

  localparam int IW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_DECODE,
    S_SCAN_ON,
    S_SCAN_OFF,
    S_ASSIGN
  } state_t;

  state_t state, state_nxt;

  // Captured message; only the 7-bit payload of the data bytes matters.
  logic [7:0] m_status;
  logic [6:0] m_d1;
  logic [6:0] m_d2;

  // Scan bookkeeping.
  logic [IW-1:0] idx;
  logic          match_found;
  logic [IW-1:0] match_idx;
  logic          free_found;
  logic [IW-1:0] free_idx;
  logic [IW-1:0] steal_ptr;

  // Voice state.
  logic [NUM_VOICES-1:0] gate_r;
  logic [6:0]            note_r [NUM_VOICES];
  logic [6:0]            vel_r  [NUM_VOICES];
  logic [NUM_VOICES-1:0] load_r;
  logic                  steal_r;

  // Bit 7 of each data byte carries no meaning for channel messages.
  logic unused_data_bits;
  assign unused_data_bits = msg_data1[7] ^ msg_data2[7];

  logic          ch_hit;
  logic          is_note_on;
  logic          is_note_off;
  logic          last_idx;
  logic [IW-1:0] tgt;
  logic          use_steal;
  logic [IW-1:0] steal_ptr_nxt;

  assign ch_hit      = (m_status[3:0] == 4'(CHANNEL));
  assign is_note_on  = (m_status[7:4] == 4'h9) && (m_d2 != 7'd0);
  assign is_note_off = (m_status[7:4] == 4'h8) || ((m_status[7:4] == 4'h9) && (m_d2 == 7'd0));
  assign last_idx    = (idx == IW'(NUM_VOICES - 1));
  assign msg_busy    = (state != S_IDLE);

  // Target choice: retrigger beats free voice, and only a full pool steals.
  always_comb begin
    tgt       = steal_ptr;
    use_steal = 1'b0;
    if (match_found) begin
      tgt = match_idx;
    end else if (free_found) begin
      tgt = free_idx;
    end else begin
      use_steal = 1'b1;
    end
    steal_ptr_nxt = (steal_ptr == IW'(NUM_VOICES - 1)) ? '0 : steal_ptr + IW'(1);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (msg_valid) state_nxt = S_DECODE;
      end
      S_DECODE: begin
        if (!ch_hit)          state_nxt = S_IDLE;
        else if (is_note_on)  state_nxt = S_SCAN_ON;
        else if (is_note_off) state_nxt = S_SCAN_OFF;
        else                  state_nxt = S_IDLE;
      end
      S_SCAN_ON: begin
        if (last_idx) state_nxt = S_ASSIGN;
      end
      S_SCAN_OFF: begin
        if (last_idx) state_nxt = S_IDLE;
      end
      S_ASSIGN: begin
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Message capture and note-on scan bookkeeping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_status    <= '0;
      m_d1        <= '0;
      m_d2        <= '0;
      idx         <= '0;
      match_found <= 1'b0;
      match_idx   <= '0;
      free_found  <= 1'b0;
      free_idx    <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (msg_valid) begin
            m_status    <= msg_status;
            m_d1        <= msg_data1[6:0];
            m_d2        <= msg_data2[6:0];
            idx         <= '0;
            match_found <= 1'b0;
            free_found  <= 1'b0;
          end
        end
        S_SCAN_ON: begin
          if (gate_r[idx] && (note_r[idx] == m_d1) && !match_found) begin
            match_found <= 1'b1;
            match_idx   <= idx;
          end
          if (!gate_r[idx] && !free_found) begin
            free_found <= 1'b1;
            free_idx   <= idx;
          end
          idx <= idx + IW'(1);
        end
        S_SCAN_OFF: begin
          idx <= idx + IW'(1);
        end
        default: begin
        end
      endcase
    end
  end

`ifdef MIDI_ALLOC_SUSTAIN_EN
  logic                  sus_flag;
  logic [NUM_VOICES-1:0] sus_r;
  logic                  is_sus_cc;

  assign is_sus_cc = ch_hit && (m_status[7:4] == 4'hB) && (m_d1 == 7'd64);

  // Voice state update with sustain: pedal-held note-offs are deferred until pedal release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r    <= '0;
      load_r    <= '0;
      steal_r   <= 1'b0;
      steal_ptr <= '0;
      sus_flag  <= 1'b0;
      sus_r     <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
      end
    end else begin
      load_r  <= '0;
      steal_r <= 1'b0;
      case (state)
        S_DECODE: begin
          if (is_sus_cc) begin
            if (m_d2[6]) begin
              sus_flag <= 1'b1;
            end else begin
              sus_flag <= 1'b0;
              gate_r   <= gate_r & ~sus_r;
              sus_r    <= '0;
            end
          end
        end
        S_SCAN_OFF: begin
          if (gate_r[idx] && (note_r[idx] == m_d1)) begin
            if (sus_flag) sus_r[idx]  <= 1'b1;
            else          gate_r[idx] <= 1'b0;
          end
        end
        S_ASSIGN: begin
          gate_r[tgt] <= 1'b1;
          sus_r[tgt]  <= 1'b0;
          note_r[tgt] <= m_d1;
          vel_r[tgt]  <= m_d2;
          load_r[tgt] <= 1'b1;
          steal_r     <= use_steal;
          if (use_steal) steal_ptr <= steal_ptr_nxt;
        end
        default: begin
        end
      endcase
    end
  end
`else
  // Voice state update: note-off clears gate, assignment loads note/vel and sets gate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gate_r    <= '0;
      load_r    <= '0;
      steal_r   <= 1'b0;
      steal_ptr <= '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        note_r[i] <= '0;
        vel_r[i]  <= '0;
      end
    end else begin
      load_r  <= '0;
      steal_r <= 1'b0;
      case (state)
        S_SCAN_OFF: begin
          if (gate_r[idx] && (note_r[idx] == m_d1)) gate_r[idx] <= 1'b0;
        end
        S_ASSIGN: begin
          gate_r[tgt] <= 1'b1;
          note_r[tgt] <= m_d1;
          vel_r[tgt]  <= m_d2;
          load_r[tgt] <= 1'b1;
          steal_r     <= use_steal;
          if (use_steal) steal_ptr <= steal_ptr_nxt;
        end
        default: begin
        end
      endcase
    end
  end
`endif

  // Pack per-voice registers onto the flat output buses.
  always_comb begin
    voice_note = '0;
    voice_vel  = '0;
    for (int i = 0; i < NUM_VOICES; i++) begin
      voice_note[7*i +: 7] = note_r[i];
      voice_vel[7*i +: 7]  = vel_r[i];
    end
  end

  assign voice_gate = gate_r;
  assign voice_load = load_r;
  assign steal      = steal_r;

endmodule

// File: tb/tb_midi_voice_alloc.sv
// Testbench for midi_voice_alloc (NUM_VOICES = 4, CHANNEL = 0).
// Stimulus pushes the hand-computed outcome of each message; a negedge monitor
// pops one record each time msg_busy falls and compares outputs and busy length.
module tb_midi_voice_alloc;

  localparam int NV = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          msg_valid = 1'b0;
  logic [7:0]    msg_status = '0;
  logic [7:0]    msg_data1 = '0;
  logic [7:0]    msg_data2 = '0;
  logic          msg_busy;
  logic [NV-1:0] voice_gate;
  logic [7*NV-1:0] voice_note;
  logic [7*NV-1:0] voice_vel;
  logic [NV-1:0] voice_load;
  logic          steal;

  midi_voice_alloc #(.NUM_VOICES(NV), .CHANNEL(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .msg_valid  (msg_valid),
    .msg_status (msg_status),
    .msg_data1  (msg_data1),
    .msg_data2  (msg_data2),
    .msg_busy   (msg_busy),
    .voice_gate (voice_gate),
    .voice_note (voice_note),
    .voice_vel  (voice_vel),
    .voice_load (voice_load),
    .steal      (steal)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [3:0]  load;
    logic        stl;
    logic [3:0]  gate;
    logic [27:0] note;
    logic [27:0] vel;
    int          len;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_id = 0;

  // Durations of msg_busy: ignored = DECODE only; note-off adds the scan; note-on adds ASSIGN.
  localparam int LEN_IGN = 1;
  localparam int LEN_OFF = NV + 1;
  localparam int LEN_ON  = NV + 2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", nm, act, req);
    end
  endtask

  function automatic logic [27:0] pk(input int v3, input int v2, input int v1, input int v0);
    return {7'(v3), 7'(v2), 7'(v1), 7'(v0)};
  endfunction

  task automatic exp_push(input logic [3:0] ld, input logic st, input logic [3:0] g,
                          input logic [27:0] n, input logic [27:0] v, input int len);
    exp_t e;
    n_id++;
    e.id = n_id; e.load = ld; e.stl = st; e.gate = g; e.note = n; e.vel = v; e.len = len;
    q.push_back(e);
  endtask

  // Waits for IDLE, then presents one message for exactly one clock.
  task automatic send(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    int t;
    t = 0;
    @(negedge clk);
    while (msg_busy && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_wait: msg_busy still high after %0d cycles, required low", t);
    end
    msg_status = s;
    msg_data1  = d1;
    msg_data2  = d2;
    msg_valid  = 1'b1;
    @(negedge clk);
    msg_valid  = 1'b0;
  endtask

  // Pulses a message while the DUT is busy; it must be dropped.
  task automatic drop(input logic [7:0] s, input logic [7:0] d1, input logic [7:0] d2);
    chk("drop_busy", {31'd0, msg_busy}, 32'd1);
    msg_status = s;
    msg_data1  = d1;
    msg_data2  = d2;
    msg_valid  = 1'b1;
    @(negedge clk);
    msg_valid  = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((q.size() != 0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("drain_queue", q.size(), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_gate"}, {28'd0, voice_gate}, 32'd0);
    chk({tag, "_note"}, {4'd0, voice_note}, 32'd0);
    chk({tag, "_vel"},  {4'd0, voice_vel}, 32'd0);
    chk({tag, "_load"}, {28'd0, voice_load}, 32'd0);
    chk({tag, "_steal"}, {31'd0, steal}, 32'd0);
    chk({tag, "_busy"}, {31'd0, msg_busy}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk_zero("reset");
    #2 rst_n = 1'b1;
  endtask

  // Monitor: one record per busy period, checked in the cycle busy falls.
  int   busy_len = 0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (!rst_n) begin
      busy_len  = 0;
      prev_busy = 1'b0;
    end else begin
      if (msg_busy) begin
        busy_len++;
      end else if (prev_busy) begin
        if (q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_msg: busy ran %0d cycles, required no message", busy_len);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk($sformatf("m%0d_load", e.id), {28'd0, voice_load}, {28'd0, e.load});
          chk($sformatf("m%0d_steal", e.id), {31'd0, steal}, {31'd0, e.stl});
          chk($sformatf("m%0d_gate", e.id), {28'd0, voice_gate}, {28'd0, e.gate});
          chk($sformatf("m%0d_note", e.id), {4'd0, voice_note}, {4'd0, e.note});
          chk($sformatf("m%0d_vel", e.id), {4'd0, voice_vel}, {4'd0, e.vel});
          chk($sformatf("m%0d_busylen", e.id), busy_len, e.len);
        end
        busy_len = 0;
      end
      prev_busy = msg_busy;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_zero("por");
    #2 rst_n = 1'b1;

    // Fill the pool in order.
    exp_push(4'b0001, 0, 4'b0001, pk(0,0,0,60),    pk(0,0,0,100),   LEN_ON); send(8'h90, 8'd60, 8'd100);
    exp_push(4'b0010, 0, 4'b0011, pk(0,0,62,60),   pk(0,0,90,100),  LEN_ON); send(8'h90, 8'd62, 8'd90);
    exp_push(4'b0100, 0, 4'b0111, pk(0,64,62,60),  pk(0,80,90,100), LEN_ON); send(8'h90, 8'd64, 8'd80);
    exp_push(4'b1000, 0, 4'b1111, pk(65,64,62,60), pk(70,80,90,100),LEN_ON); send(8'h90, 8'd65, 8'd70);
    // Full: steal voice 0, then voice 1.
    exp_push(4'b0001, 1, 4'b1111, pk(65,64,62,67), pk(70,80,90,50), LEN_ON); send(8'h90, 8'd67, 8'd50);
    exp_push(4'b0010, 1, 4'b1111, pk(65,64,69,67), pk(70,80,40,50), LEN_ON); send(8'h90, 8'd69, 8'd40);
    // Retrigger 64 on voice 2, no steal.
    exp_push(4'b0100, 0, 4'b1111, pk(65,64,69,67), pk(70,33,40,50), LEN_ON); send(8'h90, 8'd64, 8'd33);
    // Note-off 64 releases voice 2; note held.
    exp_push(4'b0000, 0, 4'b1011, pk(65,64,69,67), pk(70,33,40,50), LEN_OFF); send(8'h80, 8'd64, 8'd0);
    // Velocity-0 note-on for a released note: no effect.
    exp_push(4'b0000, 0, 4'b1011, pk(65,64,69,67), pk(70,33,40,50), LEN_OFF); send(8'h90, 8'd64, 8'd0);
    // Free voice 2 preferred over steal.
    exp_push(4'b0100, 0, 4'b1111, pk(65,71,69,67), pk(70,20,40,50), LEN_ON); send(8'h90, 8'd71, 8'd20);
    // Steal pointer still 2, then 3, then wraps to 0.
    exp_push(4'b0100, 1, 4'b1111, pk(65,73,69,67), pk(70,10,40,50), LEN_ON); send(8'h90, 8'd73, 8'd10);
    exp_push(4'b1000, 1, 4'b1111, pk(75,73,69,67), pk(11,10,40,50), LEN_ON); send(8'h90, 8'd75, 8'd11);
    exp_push(4'b0000, 0, 4'b1110, pk(75,73,69,67), pk(11,10,40,50), LEN_OFF); send(8'h80, 8'd67, 8'd0);
    exp_push(4'b0001, 0, 4'b1111, pk(75,73,69,77), pk(11,10,40,12), LEN_ON); send(8'h90, 8'd77, 8'd12);
    exp_push(4'b0001, 1, 4'b1111, pk(75,73,69,79), pk(11,10,40,13), LEN_ON); send(8'h90, 8'd79, 8'd13);
    // Other channel ignored; a message during busy is dropped.
    exp_push(4'b0000, 0, 4'b1111, pk(75,73,69,79), pk(11,10,40,13), LEN_IGN); send(8'h93, 8'd60, 8'd100);
    drop(8'h90, 8'd50, 8'd99);
    // Data bit 7 ignored: note 60 vel 5, steals voice 1.
    exp_push(4'b0010, 1, 4'b1111, pk(75,73,60,79), pk(11,10,5,13), LEN_ON); send(8'h90, 8'd188, 8'd133);
    exp_push(4'b0000, 0, 4'b1011, pk(75,73,60,79), pk(11,10,5,13), LEN_OFF); send(8'h80, 8'd201, 8'd0);
    exp_push(4'b0000, 0, 4'b1011, pk(75,73,60,79), pk(11,10,5,13), LEN_OFF); send(8'h80, 8'd61, 8'd0);
    drop(8'h90, 8'd40, 8'd40);
    exp_push(4'b0000, 0, 4'b1011, pk(75,73,60,79), pk(11,10,5,13), LEN_IGN); send(8'h81, 8'd75, 8'd0);
    drain();

    // Reset mid-scan: everything clears at once, message lost.
    send(8'h90, 8'd80, 8'd1);
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk_zero("midreset");
    @(negedge clk);
    @(negedge clk);
    #2 rst_n = 1'b1;

    // Retrigger after reset keeps voice 1 free.
    exp_push(4'b0001, 0, 4'b0001, pk(0,0,0,60),  pk(0,0,0,100), LEN_ON); send(8'h90, 8'd60, 8'd100);
    exp_push(4'b0001, 0, 4'b0001, pk(0,0,0,60),  pk(0,0,0,50),  LEN_ON); send(8'h90, 8'd60, 8'd50);
    exp_push(4'b0010, 0, 4'b0011, pk(0,0,62,60), pk(0,0,90,50), LEN_ON); send(8'h90, 8'd62, 8'd90);
    drain();

    do_reset();
`ifdef MIDI_ALLOC_SUSTAIN_EN
    exp_push(4'b0000, 0, 4'b0000, pk(0,0,0,0),  pk(0,0,0,0),   LEN_IGN); send(8'hB0, 8'd64, 8'd127);
    exp_push(4'b0001, 0, 4'b0001, pk(0,0,0,60), pk(0,0,0,100), LEN_ON);  send(8'h90, 8'd60, 8'd100);
    exp_push(4'b0000, 0, 4'b0001, pk(0,0,0,60), pk(0,0,0,100), LEN_OFF); send(8'h80, 8'd60, 8'd0);
    exp_push(4'b0000, 0, 4'b0000, pk(0,0,0,60), pk(0,0,0,100), LEN_IGN); send(8'hB0, 8'd64, 8'd0);
`else
    exp_push(4'b0000, 0, 4'b0000, pk(0,0,0,0),  pk(0,0,0,0),   LEN_IGN); send(8'hB0, 8'd64, 8'd127);
    exp_push(4'b0001, 0, 4'b0001, pk(0,0,0,60), pk(0,0,0,100), LEN_ON);  send(8'h90, 8'd60, 8'd100);
    exp_push(4'b0000, 0, 4'b0000, pk(0,0,0,60), pk(0,0,0,100), LEN_OFF); send(8'h80, 8'd60, 8'd0);
`endif
    drain();
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/midi_voice_alloc.md
# midi_voice_alloc

Polyphonic voice allocator. It sits downstream of the MIDI receive controller and consumes complete three-byte channel messages. It assigns note-on events to a pool of NUM_VOICES synth voices, releases them on note-off, and steals a voice round-robin when the pool is full. Per-voice gate/note/velocity outputs drive the tone generators.

## Interface
- NUM_VOICES, default 4: voice count, 2..16.
- CHANNEL, default 0: MIDI channel (0..15) this allocator responds to.

- clk  in  1: clock.
- rst_n  in  1: reset, asynchronous, active-low.
- msg_valid  in  1: one-cycle pulse, message bytes valid.
- msg_status  in  8: status byte.
- msg_data1  in  8: data byte 1 (note / controller number).
- msg_data2  in  8: data byte 2 (velocity / controller value).
- msg_busy  out  1: high when state != IDLE. msg_valid while busy is dropped.
- voice_gate  out  NUM_VOICES: per-voice key-down.
- voice_note  out  7*NUM_VOICES: per-voice note. Voice i occupies bits [7i+6:7i].
- voice_vel  out  7*NUM_VOICES: per-voice velocity, same packing.
- voice_load  out  NUM_VOICES: one-cycle pulse when voice i gets a new note/vel.
- steal  out  1: one-cycle pulse, same cycle as voice_load, when the assignment stole a gated voice.

## Operation
- States: IDLE, DECODE, SCAN_ON, SCAN_OFF, ASSIGN.
- IDLE: on msg_valid, capture the three bytes and go to DECODE.
- DECODE:
  - If status[3:0] != CHANNEL, go to IDLE.
  - If status[7:4] == 0x9 and data2[6:0] != 0, this is a note-on: go to SCAN_ON.
  - If status[7:4] == 0x8, or 0x9 with velocity 0, this is a note-off: go to SCAN_OFF.
  - All other messages go to IDLE (see Configuration).
- SCAN_ON: visits index 0..NUM_VOICES-1, one voice per cycle.
  - Records the first gated voice whose note == data1[6:0] (retrigger match).
  - Records the lowest-index voice with gate low (free).
  - After the last index, go to ASSIGN.
- ASSIGN: target selection priority is retrigger match, then lowest free, then steal_ptr.
  - Load note = data1[6:0] and vel = data2[6:0], set gate.
  - Pulse voice_load[target]. Pulse steal if steal_ptr was used.
  - On a steal, steal_ptr increments mod NUM_VOICES (NUM_VOICES-1 wraps to 0).
  - Go to IDLE.
- SCAN_OFF: visits voices one per cycle. Every gated voice with a matching note has its gate cleared; note and vel are held. After the last index, go to IDLE. No match means no effect.
- Only data bits [6:0] are used; bit 7 is ignored.

## Timing
- Reset values: all outputs 0, state IDLE, steal_ptr 0, all voice registers 0.
- Accept at edge k. DECODE runs in cycle k+1. Scan runs in cycles k+2..k+NUM_VOICES+1.
- Note-on: ASSIGN in cycle k+NUM_VOICES+2. voice_gate/note/vel and the voice_load/steal pulses are registered out in cycle k+NUM_VOICES+3.
- Note-off: gate falls in the cycle after the matching voice is scanned.
- msg_busy rises the cycle after accept and falls when IDLE is re-entered. A new msg_valid is accepted in that same IDLE cycle.
- Ignored message: msg_busy high for exactly 1 cycle (DECODE).
- Async reset mid-operation: every output clears immediately and the in-flight message is lost.

## Configuration
- MIDI_ALLOC_SUSTAIN_EN defined: enables the sustain pedal (control change 0xB, data1 == 64).
  - data2 >= 64 sets the sustain flag. data2 < 64 clears the flag and clears the gate of every sustained voice in DECODE.
  - While the sustain flag is set, a SCAN_OFF match marks the voice as sustained instead of clearing its gate.
  - A sustained voice counts as gated, so it is not free. A retrigger note-on clears its sustained mark.
  - The sustain flag resets to 0.
- MIDI_ALLOC_SUSTAIN_EN undefined: CC messages are ignored like all other non-note messages, and no sustain state exists.

## Test plan
- Reset, then note-on 0x90/60/100: voice 0 gated with note 60 and vel 100. voice_load = 0001 at k+7 (NUM_VOICES = 4). steal = 0.
- Notes 60, 62, 64, 65, then 67: voices 0..3 fill in order. Note 67 steals voice 0 with steal pulsed, and steal_ptr becomes 1.
- Note-on 60 twice: second note-on retriggers voice 0 only, and voice 1 stays free.
- Note-on 60, then 0x90/60/0: gate 0 falls and note 60 is held. Then 0x80/61/0 has no effect.
- Note-on to channel 3 (0x93) with CHANNEL = 0: ignored, and msg_busy is high for 1 cycle. msg_valid during busy is dropped.
- With SUSTAIN_EN: CC64 = 127, note-on 60, note-off 60 leaves voice 0 gated. CC64 = 0 then clears voice 0's gate.
